// File: rtl/mips_cpu_lsu_pkg.sv
// rtl/mips_cpu_lsu_pkg.sv - shared encodings, state enum and request legality check for the LSU
package mips_cpu_lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_RD,
    ST_STORE_RD,
    ST_STORE_WR,
    ST_RESP
  } lsu_state_t;

  // High when the request must be rejected: misaligned half/word or the reserved size code.
  function automatic logic req_bad(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = lane[0];
      SIZE_WORD: bad = (lane != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mips_cpu_lsu_align.sv
// rtl/mips_cpu_lsu_align.sv - little-endian lane extract/extend for loads and lane merge for stores
module mips_cpu_lsu_align
  import mips_cpu_lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [1:0]  lane,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = rdata[{lane, 3'b000} +: 8];
    half_sel  = lane[1] ? rdata[31:16] : rdata[15:0];
    load_data = rdata;
    merged    = wdata;
    case (size)
      SIZE_BYTE: begin
        load_data = {{24{is_signed & byte_sel[7]}}, byte_sel};
        merged    = rdata;
        merged[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SIZE_HALF: begin
        load_data = {{16{is_signed & half_sel[15]}}, half_sel};
        merged    = lane[1] ? {wdata[15:0], rdata[15:0]} : {rdata[31:16], wdata[15:0]};
      end
      default: begin
        load_data = rdata;
        merged    = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mips_cpu_lsu.sv
// rtl/mips_cpu_lsu.sv - load/store unit driving a word-wide data memory without byte enables
module mips_cpu_lsu
  import mips_cpu_lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  lsu_state_t    state;
  logic          store_q;
  logic          signed_q;
  logic [1:0]    size_q;
  logic [31:0]   addr_q;
  logic [31:0]   word_q;
  logic [CW-1:0] stall_cnt;
  logic          timed_out;
  logic [31:0]   load_data;
  logic [31:0]   merged;

  mips_cpu_lsu_align u_align (
    .size      (size_q),
    .is_signed (signed_q),
    .lane      (addr_q[1:0]),
    .rdata     (mem_readdata),
    .wdata     (word_q),
    .load_data (load_data),
    .merged    (merged)
  );

  // Strobes decode from state, so an asynchronous reset drops them immediately.
  assign req_ready     = (state == ST_IDLE);
  assign mem_read      = (state == ST_LOAD_RD) || (state == ST_STORE_RD);
  assign mem_write     = (state == ST_STORE_WR);
  assign mem_address   = {addr_q[31:2], 2'b00};
  assign mem_writedata = word_q;
  assign timed_out     = (TIMEOUT != 0) && (stall_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      store_q    <= 1'b0;
      signed_q   <= 1'b0;
      size_q     <= SIZE_BYTE;
      addr_q     <= '0;
      word_q     <= '0;
      stall_cnt  <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            store_q   <= req_store;
            signed_q  <= req_signed;
            size_q    <= req_size;
            addr_q    <= req_addr;
            word_q    <= req_wdata;
            stall_cnt <= '0;
            if (req_bad(req_size, req_addr[1:0])) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (!req_store) begin
              state <= ST_LOAD_RD;
            end else if (req_size == SIZE_WORD) begin
              state <= ST_STORE_WR;
            end else begin
              state <= ST_STORE_RD;
            end
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: begin
          if (!mem_waitrequest) begin
            stall_cnt <= '0;
            case (state)
              ST_LOAD_RD: begin
                state      <= ST_RESP;
                resp_valid <= 1'b1;
                resp_err   <= 1'b0;
                resp_rdata <= load_data;
              end
              ST_STORE_RD: begin
                word_q <= merged;
                state  <= ST_STORE_WR;
              end
              default: begin
                state      <= ST_RESP;
                resp_valid <= 1'b1;
                resp_err   <= 1'b0;
                resp_rdata <= '0;
              end
            endcase
          end else if (timed_out) begin
            // Abort leaves memory untouched: a write only commits on a non-stalled edge.
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  logic unused_store;
  assign unused_store = store_q;

endmodule

// File: tb/tb_mips_cpu_lsu.sv
// tb/tb_mips_cpu_lsu.sv - scoreboard bench for mips_cpu_lsu with a word memory model
module tb_mips_cpu_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_waitrequest;

  mips_cpu_lsu #(.TIMEOUT(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_store       (req_store),
    .req_size        (req_size),
    .req_signed      (req_signed),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_err        (resp_err),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_writedata   (mem_writedata),
    .mem_readdata    (mem_readdata),
    .mem_waitrequest (mem_waitrequest)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:255];
  int          stall_left;
  assign mem_readdata    = mem[mem_address[9:2]];
  assign mem_waitrequest = (stall_left != 0);

  always @(posedge clk) begin
    if (mem_write && !mem_waitrequest) mem[mem_address[9:2]] <= mem_writedata;
    if ((mem_read || mem_write) && stall_left != 0) stall_left <= stall_left - 1;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   neg_cyc = 0;
  int   dual_cnt = 0;
  int   next_id = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    neg_cyc++;
    if (mem_read && mem_write) dual_cnt++;
    if (rst_n && resp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("resp_rdata#%0d", e.id), resp_rdata, e.rdata);
        check($sformatf("resp_err#%0d", e.id), {31'd0, resp_err}, {31'd0, e.err});
        check($sformatf("resp_latency#%0d", e.id), neg_cyc - e.acc, e.lat);
      end
    end
  end

  // Drives one request; returns at the negedge of cycle T+1.
  task automatic issue(input logic st, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                       input int lat);
    exp_t e;
    int   n;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      check("req_ready_wait", 32'd0, 32'd1);
      return;
    end
    req_valid = 1'b1; req_store = st; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    e.rdata = exp_rd; e.err = exp_err; e.lat = lat; e.acc = neg_cyc; e.id = next_id;
    next_id++;
    sb.push_back(e);
    @(negedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain;
    int n;
    n = 0;
    while ((sb.size() != 0 || !req_ready) && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    check("drain", {31'd0, (sb.size() == 0 && req_ready)}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[32'h200 >> 2] = 32'h12345678;
    mem[32'h300 >> 2] = 32'hCAFEF00D;
    stall_left = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    #12;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    check("rst_mem_address", mem_address, 32'd0);
    check("rst_mem_writedata", mem_writedata, 32'd0);
    check("rst_resp", {resp_rdata[30:0], resp_valid | resp_err}, 32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;

    // word store then word load
    issue(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    check("ws_write", {31'd0, mem_write}, 32'd1);
    check("ws_addr", mem_address, 32'h100);
    check("ws_wdata", mem_writedata, 32'hDEADBEEF);
    @(negedge clk); #1;
    check("ws_write_one_cycle", {31'd0, mem_write}, 32'd0);
    drain();
    check("byte100", {24'd0, mem[64][7:0]}, 32'hEF);
    check("byte101", {24'd0, mem[64][15:8]}, 32'hBE);
    check("byte102", {24'd0, mem[64][23:16]}, 32'hAD);
    check("byte103", {24'd0, mem[64][31:24]}, 32'hDE);
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 2);

    // extended loads, issued back-to-back
    issue(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'hFFFFFFDE, 1'b0, 2);
    issue(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h000000DE, 1'b0, 2);
    issue(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'hFFFFDEAD, 1'b0, 2);
    issue(1'b0, 2'b01, 1'b0, 32'h100, 32'h0, 32'h0000BEEF, 1'b0, 2);
    issue(1'b0, 2'b00, 1'b1, 32'h100, 32'h0, 32'hFFFFFFEF, 1'b0, 2);
    drain();

    // byte store read-modify-write
    issue(1'b1, 2'b00, 1'b0, 32'h101, 32'h00000055, 32'h0, 1'b0, 3);
    check("bs_read", {30'd0, mem_read, mem_write}, 32'd2);
    check("bs_raddr", mem_address, 32'h100);
    @(negedge clk); #1;
    check("bs_write", {30'd0, mem_read, mem_write}, 32'd1);
    check("bs_waddr", mem_address, 32'h100);
    check("bs_wdata", mem_writedata, 32'hDEAD55EF);
    drain();
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEAD55EF, 1'b0, 2);
    issue(1'b1, 2'b01, 1'b0, 32'h102, 32'h0000A5C3, 32'h0, 1'b0, 3);
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hA5C355EF, 1'b0, 2);
    drain();

    // rejected requests
    issue(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h0, 1'b1, 1);
    check("err_no_strobe", {30'd0, mem_read, mem_write}, 32'd0);
    issue(1'b0, 2'b11, 1'b0, 32'h104, 32'h0, 32'h0, 1'b1, 1);
    check("ill_no_strobe", {30'd0, mem_read, mem_write}, 32'd0);
    issue(1'b1, 2'b01, 1'b0, 32'h101, 32'hFFFF, 32'h0, 1'b1, 1);
    check("mis_st_no_strobe", {30'd0, mem_read, mem_write}, 32'd0);
    drain();

    // three stall cycles on a load
    stall_left = 3;
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hA5C355EF, 1'b0, 5);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("stall_read%0d", i), {31'd0, mem_read}, 32'd1);
      check($sformatf("stall_addr%0d", i), mem_address, 32'h100);
      @(negedge clk); #1;
    end
    drain();

    // timeout on a word store
    stall_left = 1000;
    issue(1'b1, 2'b10, 1'b0, 32'h200, 32'hFFFFFFFF, 32'h0, 1'b1, 5);
    drain();
    stall_left = 0;
    check("timeout_mem", mem[32'h200 >> 2], 32'h12345678);

    // reset during a stalled write
    stall_left = 1000;
    issue(1'b1, 2'b10, 1'b0, 32'h300, 32'h11111111, 32'h0, 1'b0, 2);
    check("rstw_write_before", {31'd0, mem_write}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstw_write_drop", {31'd0, mem_write}, 32'd0);
    sb.delete();
    @(negedge clk); #1;
    stall_left = 0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    check("rstw_mem", mem[32'h300 >> 2], 32'hCAFEF00D);
    check("rstw_ready", {31'd0, req_ready}, 32'd1);
    issue(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'hCAFEF00D, 1'b0, 2);
    drain();

    check("no_dual_strobe", dual_cnt, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
